vc_output_scheduler: RTL and testbench

//  Sequences one router output port that is shared by NUM_REQ input channels (e.g. cw, ccw, pe).

---
 rtl/vc_output_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_vc_output_scheduler.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_output_scheduler.sv
// vc_output_scheduler
// Control sequencer for one router output link shared by NUM_REQ input
// channels. The even and odd virtual channels each own a round-robin
// arbiter and a one-entry output buffer FSM (IDLE -> GRANT -> FULL -> SEND).
// The block drives grant, buffer-load, mux-select and send controls for the
// output datapath, plus the link polarity (even VC sends on phase 0, odd VC
// on phase 1, so the two VCs never drive the link in the same cycle).
// Every output is a register; nothing flows combinationally from an input
// to an output.
//
// Optional feature: define VC_STALL_CNT_EN to add per-VC saturating stall
// counters (stall_cnt_even / stall_cnt_odd, CNT_W bits) that count cycles
// spent in FULL while ro is low and clear on the edge that enters SEND.
module vc_output_scheduler #(
    parameter int NUM_REQ   = 3,
    parameter int REQ_IDX_W = 2
`ifdef VC_STALL_CNT_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ro,
    input  logic [NUM_REQ-1:0]   req_even,
    input  logic [NUM_REQ-1:0]   req_odd,
    output logic [NUM_REQ-1:0]   grant_even,
    output logic [NUM_REQ-1:0]   grant_odd,
    output logic                 load_even,
    output logic                 load_odd,
    output logic [REQ_IDX_W-1:0] sel_even,
    output logic [REQ_IDX_W-1:0] sel_odd,
    output logic                 send,
    output logic                 send_vc,
    output logic                 polarity
`ifdef VC_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]     stall_cnt_even,
    output logic [CNT_W-1:0]     stall_cnt_odd
`endif
);

    // Per-VC buffer FSM encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam logic [1:0] ST_SEND  = 2'd3;

    // Index 0 is the even VC, index 1 the odd VC.
    logic [1:0][NUM_REQ-1:0]   req_vc;
    logic [1:0][NUM_REQ-1:0]   grant_vc;
    logic [1:0]                load_vc;
    logic [1:0][REQ_IDX_W-1:0] sel_vc;
    logic [1:0]                enter_send;
`ifdef VC_STALL_CNT_EN
    logic [1:0][CNT_W-1:0]     stall_vc;
`endif

    assign req_vc[0] = req_even;
    assign req_vc[1] = req_odd;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_vc
            // Link phase on which this VC is allowed to leave FULL.
            localparam logic PHASE = (gi == 1);

            logic [1:0]           state_reg;
            logic [1:0]           state_next;
            logic [REQ_IDX_W-1:0] ptr_reg;
            logic [REQ_IDX_W-1:0] ptr_next;
            logic [REQ_IDX_W-1:0] winner;
            logic [REQ_IDX_W:0]   cand;
            logic [NUM_REQ-1:0]   grant_next;
            logic                 any_req;
            logic                 latch_winner;
            logic [NUM_REQ-1:0]   grant_reg;
            logic                 load_reg;
            logic [REQ_IDX_W-1:0] sel_reg;

            // Round-robin pick: scan upward from ptr (mod NUM_REQ). Walking the
            // offsets from high to low lets the lowest offset overwrite last,
            // so the first requester at or after ptr wins.
            always_comb begin
                winner = '0;
                cand   = '0;
                for (int k = NUM_REQ - 1; k >= 0; k--) begin
                    cand = {1'b0, ptr_reg} + (REQ_IDX_W + 1)'(k);
                    if (cand >= (REQ_IDX_W + 1)'(NUM_REQ)) begin
                        cand = cand - (REQ_IDX_W + 1)'(NUM_REQ);
                    end
                    if (req_vc[gi][cand[REQ_IDX_W-1:0]]) begin
                        winner = cand[REQ_IDX_W-1:0];
                    end
                end
            end

            // Pointer advances past the winner, wrapping at NUM_REQ.
            always_comb begin
                ptr_next = ptr_reg;
                if (winner == REQ_IDX_W'(NUM_REQ - 1)) begin
                    ptr_next = '0;
                end else begin
                    ptr_next = winner + 1'b1;
                end
            end

            assign any_req      = |req_vc[gi];
            // Requests are only looked at when the buffer is free or emptying.
            assign latch_winner = any_req &&
                                  ((state_reg == ST_IDLE) || (state_reg == ST_SEND));
            assign grant_next   = NUM_REQ'(1) << winner;

            // Buffer FSM next-state decode.
            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    ST_IDLE:  if (any_req) state_next = ST_GRANT;
                    ST_GRANT: state_next = ST_FULL;
                    ST_FULL:  if (ro && (polarity == PHASE)) state_next = ST_SEND;
                    ST_SEND:  state_next = any_req ? ST_GRANT : ST_IDLE;
                    default:  state_next = ST_IDLE;
                endcase
            end

            // State, pointer and the registered GRANT-state outputs.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_reg <= ST_IDLE;
                    ptr_reg   <= '0;
                    grant_reg <= '0;
                    load_reg  <= 1'b0;
                    sel_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    grant_reg <= latch_winner ? grant_next : '0;
                    load_reg  <= latch_winner;
                    if (latch_winner) begin
                        ptr_reg <= ptr_next;
                        sel_reg <= winner;
                    end
                end
            end

            assign grant_vc[gi]   = grant_reg;
            assign load_vc[gi]    = load_reg;
            assign sel_vc[gi]     = sel_reg;
            assign enter_send[gi] = (state_next == ST_SEND);

`ifdef VC_STALL_CNT_EN
            logic [CNT_W-1:0] stall_reg;

            // Saturating count of FULL cycles blocked by ro; cleared on SEND entry.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    stall_reg <= '0;
                end else if (state_next == ST_SEND) begin
                    stall_reg <= '0;
                end else if ((state_reg == ST_FULL) && !ro && !(&stall_reg)) begin
                    stall_reg <= stall_reg + 1'b1;
                end
            end

            assign stall_vc[gi] = stall_reg;
`endif
        end
    endgenerate

    // Shared link controls: send/send_vc are decoded from the next VC states
    // so they are valid exactly while a VC sits in SEND; polarity free-runs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            send     <= 1'b0;
            send_vc  <= 1'b0;
            polarity <= 1'b0;
        end else begin
            send     <= |enter_send;
            send_vc  <= enter_send[1];
            polarity <= ~polarity;
        end
    end

    assign grant_even = grant_vc[0];
    assign grant_odd  = grant_vc[1];
    assign load_even  = load_vc[0];
    assign load_odd   = load_vc[1];
    assign sel_even   = sel_vc[0];
    assign sel_odd    = sel_vc[1];
`ifdef VC_STALL_CNT_EN
    assign stall_cnt_even = stall_vc[0];
    assign stall_cnt_odd  = stall_vc[1];
`endif

endmodule

// File: tb/tb_vc_output_scheduler.sv
// tb_vc_output_scheduler
// Scoreboard bench: each scenario task pushes the grants it expects per VC,
// and step() pops them as the DUT produces grants and tracks buffer
// occupancy to validate every send. Build with VC_STALL_CNT_EN defined to
// also check the stall counters.
module tb_vc_output_scheduler;

    localparam int NUM_REQ   = 3;
    localparam int REQ_IDX_W = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 ro;
    logic [NUM_REQ-1:0]   req_even;
    logic [NUM_REQ-1:0]   req_odd;
    logic [NUM_REQ-1:0]   grant_even;
    logic [NUM_REQ-1:0]   grant_odd;
    logic                 load_even;
    logic                 load_odd;
    logic [REQ_IDX_W-1:0] sel_even;
    logic [REQ_IDX_W-1:0] sel_odd;
    logic                 send;
    logic                 send_vc;
    logic                 polarity;
`ifdef VC_STALL_CNT_EN
    logic [15:0]          stall_cnt_even;
    logic [15:0]          stall_cnt_odd;
`endif

    vc_output_scheduler #(
        .NUM_REQ   (NUM_REQ),
        .REQ_IDX_W (REQ_IDX_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ro         (ro),
        .req_even   (req_even),
        .req_odd    (req_odd),
        .grant_even (grant_even),
        .grant_odd  (grant_odd),
        .load_even  (load_even),
        .load_odd   (load_odd),
        .sel_even   (sel_even),
        .sel_odd    (sel_odd),
        .send       (send),
        .send_vc    (send_vc),
        .polarity   (polarity)
`ifdef VC_STALL_CNT_EN
        ,
        .stall_cnt_even (stall_cnt_even),
        .stall_cnt_odd  (stall_cnt_odd)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [NUM_REQ-1:0] exp_q [2][$];
    int pending        [2];
    bit hold           [2];
    int last_grant_cyc [2];
    int last_send_cyc  [2];
    int grants_seen    [2];
    int sends_seen     [2];

    function automatic logic [REQ_IDX_W-1:0] oh_idx(input logic [NUM_REQ-1:0] oh);
        oh_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (oh[i]) oh_idx = REQ_IDX_W'(i);
        end
    endfunction

    // Advance one cycle, sample at the falling edge, score grants and sends,
    // and play the requester (drop a granted request unless held).
    task automatic step();
        logic [NUM_REQ-1:0]   gv;
        logic [NUM_REQ-1:0]   e;
        logic                 lv;
        logic [REQ_IDX_W-1:0] sv;
        int                   v;
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            gv = (k == 0) ? grant_even : grant_odd;
            lv = (k == 0) ? load_even  : load_odd;
            sv = (k == 0) ? sel_even   : sel_odd;
            if (gv != '0 || lv) begin
                checks++;
                if (exp_q[k].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_grant vc=%0d got grant=%b load=%b, expected no grant", k, gv, lv);
                end else begin
                    e = exp_q[k].pop_front();
                    if (gv !== e || lv !== 1'b1 || sv !== oh_idx(e)) begin
                        errors++;
                        $display("FAIL grant vc=%0d got grant=%b load=%b sel=%0d, expected grant=%b load=1 sel=%0d",
                                 k, gv, lv, sv, e, oh_idx(e));
                    end
                end
                checks++;
                if (pending[k] != 0) begin
                    errors++;
                    $display("FAIL grant_into_full vc=%0d got occupancy=%0d, expected 0", k, pending[k]);
                end
                $display("grant vc=%0d grant=%b sel=%0d cyc=%0d", k, gv, sv, cyc);
                pending[k]        = 1;
                last_grant_cyc[k] = cyc;
                grants_seen[k]++;
                if (!hold[k]) begin
                    if (k == 0) req_even = req_even & ~gv;
                    else        req_odd  = req_odd  & ~gv;
                end
            end
        end
        if (send) begin
            v = int'(send_vc);
            checks++;
            if (pending[v] != 1) begin
                errors++;
                $display("FAIL unexpected_send vc=%0d got send with occupancy=%0d, expected 1", v, pending[v]);
            end
            checks++;
            if (polarity !== ~send_vc) begin
                errors++;
                $display("FAIL send_phase vc=%0d got polarity=%b, expected %b", v, polarity, ~send_vc);
            end
            checks++;
            if (ro !== 1'b1) begin
                errors++;
                $display("FAIL send_without_ro vc=%0d got ro=%b at send edge, expected 1", v, ro);
            end
            $display("send vc=%0d cyc=%0d", v, cyc);
            pending[v]       = 0;
            last_send_cyc[v] = cyc;
            sends_seen[v]++;
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (exp_q[0].size() == 0 && exp_q[1].size() == 0 &&
                pending[0] == 0 && pending[1] == 0) break;
            step();
        end
        checks++;
        if (exp_q[0].size() != 0 || exp_q[1].size() != 0 || pending[0] != 0 || pending[1] != 0) begin
            errors++;
            $display("FAIL %s_timeout got outstanding grants=%0d/%0d flits=%0d/%0d, expected all 0",
                     name, exp_q[0].size(), exp_q[1].size(), pending[0], pending[1]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b0;
        req_even = '0;
        req_odd  = '0;
        ro       = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q[k].delete();
            pending[k] = 0;
            hold[k]    = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        ro       = 1'b1;
        req_even = '0;
        req_odd  = '0;
        for (int k = 0; k < 2; k++) begin
            pending[k] = 0; hold[k] = 1'b0; grants_seen[k] = 0; sends_seen[k] = 0;
        end
        #12;
        checks++;
        if ({grant_even, grant_odd, load_even, load_odd, sel_even, sel_odd, send, send_vc, polarity} !== '0) begin
            errors++;
            $display("FAIL reset_state got g=%b/%b l=%b/%b s=%0d/%0d send=%b vc=%b pol=%b, expected all 0",
                     grant_even, grant_odd, load_even, load_odd, sel_even, sel_odd, send, send_vc, polarity);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_idle();
        logic exp_pol;
        exp_pol = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            exp_pol = ~exp_pol;
            checks++;
            if ({grant_even, grant_odd, load_even, load_odd, send} !== '0 || polarity !== exp_pol) begin
                errors++;
                $display("FAIL idle cyc=%0d got g=%b/%b l=%b/%b send=%b pol=%b, expected zeros pol=%b",
                         i, grant_even, grant_odd, load_even, load_odd, send, polarity, exp_pol);
            end
        end
    endtask

    task automatic test_single();
        int start, s0;
        do_reset();
        s0 = sends_seen[0];
        exp_q[0].push_back(3'b001);
        req_even = 3'b001;
        start    = cyc;
        wait_drain(20, "single");
        checks++;
        if (last_grant_cyc[0] - start != 1) begin
            errors++;
            $display("FAIL single_grant_latency got %0d, expected 1", last_grant_cyc[0] - start);
        end
        checks++;
        if (last_send_cyc[0] - last_grant_cyc[0] != 2 && last_send_cyc[0] - last_grant_cyc[0] != 3) begin
            errors++;
            $display("FAIL single_send_latency got %0d, expected 2 or 3", last_send_cyc[0] - last_grant_cyc[0]);
        end
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (sends_seen[0] - s0 != 1 || sel_even !== 2'd0) begin
            errors++;
            $display("FAIL single_once got sends=%0d sel=%0d, expected 1 and 0", sends_seen[0] - s0, sel_even);
        end
    endtask

    task automatic test_round_robin();
        int target, s0;
        do_reset();
        s0      = sends_seen[0];
        hold[0] = 1'b1;
        exp_q[0].push_back(3'b001);
        exp_q[0].push_back(3'b010);
        exp_q[0].push_back(3'b100);
        exp_q[0].push_back(3'b001);
        target   = grants_seen[0] + 4;
        req_even = 3'b111;
        for (int i = 0; i < 60 && grants_seen[0] < target; i++) step();
        req_even = '0;
        hold[0]  = 1'b0;
        checks++;
        if (grants_seen[0] != target) begin
            errors++;
            $display("FAIL rr_grants got %0d grants, expected 4", 4 - (target - grants_seen[0]));
        end
        wait_drain(20, "rr");
        checks++;
        if (sends_seen[0] - s0 != 4) begin
            errors++;
            $display("FAIL rr_sends got %0d, expected 4", sends_seen[0] - s0);
        end
    endtask

    task automatic test_both_vc();
        int d;
        do_reset();
        exp_q[0].push_back(3'b001);
        exp_q[1].push_back(3'b010);
        req_even = 3'b001;
        req_odd  = 3'b010;
        wait_drain(20, "both");
        checks++;
        if (last_grant_cyc[0] != last_grant_cyc[1]) begin
            errors++;
            $display("FAIL both_grant_same_cycle got even=%0d odd=%0d, expected equal",
                     last_grant_cyc[0], last_grant_cyc[1]);
        end
        d = last_send_cyc[1] - last_send_cyc[0];
        checks++;
        if (d != 1 && d != -1) begin
            errors++;
            $display("FAIL both_send_alternate got spacing=%0d, expected +/-1", d);
        end
    endtask

    task automatic test_stall();
        int s0;
        do_reset();
        ro = 1'b0;
        exp_q[0].push_back(3'b001);
        req_even = 3'b001;
        for (int i = 0; i < 5 && pending[0] == 0; i++) step();
        s0 = sends_seen[0];
        for (int i = 0; i < 11; i++) step();
        checks++;
        if (sends_seen[0] != s0 || pending[0] != 1) begin
            errors++;
            $display("FAIL stall_hold got sends=%0d occupancy=%0d, expected 0 and 1", sends_seen[0] - s0, pending[0]);
        end
`ifdef VC_STALL_CNT_EN
        checks++;
        if (stall_cnt_even !== 16'd10) begin
            errors++;
            $display("FAIL stall_cnt_before got %0d, expected 10", stall_cnt_even);
        end
`endif
        ro = 1'b1;
        for (int i = 0; i < 4 && pending[0] != 0; i++) step();
        checks++;
        if (sends_seen[0] - s0 != 1) begin
            errors++;
            $display("FAIL stall_release got sends=%0d, expected 1", sends_seen[0] - s0);
        end
`ifdef VC_STALL_CNT_EN
        checks++;
        if (stall_cnt_even !== 16'd0) begin
            errors++;
            $display("FAIL stall_cnt_after got %0d, expected 0", stall_cnt_even);
        end
`endif
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (sends_seen[0] - s0 != 1) begin
            errors++;
            $display("FAIL stall_once got sends=%0d, expected 1", sends_seen[0] - s0);
        end
    endtask

    task automatic test_reset_mid();
        int g0;
        do_reset();
        ro = 1'b0;
        exp_q[0].push_back(3'b010);
        req_even = 3'b010;
        for (int i = 0; i < 5 && pending[0] == 0; i++) step();
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({grant_even, grant_odd, load_even, load_odd, sel_even, sel_odd, send, send_vc, polarity} !== '0) begin
            errors++;
            $display("FAIL async_reset got g=%b/%b l=%b/%b s=%0d/%0d send=%b vc=%b pol=%b, expected all 0",
                     grant_even, grant_odd, load_even, load_odd, sel_even, sel_odd, send, send_vc, polarity);
        end
        pending[0] = 0;
        exp_q[0].delete();
        req_even = '0;
        @(negedge clk);
        rst     = 1'b1;
        ro      = 1'b1;
        hold[0] = 1'b1;
        exp_q[0].push_back(3'b001);
        g0       = grants_seen[0];
        req_even = 3'b111;
        for (int i = 0; i < 5 && grants_seen[0] == g0; i++) step();
        req_even = '0;
        hold[0]  = 1'b0;
        wait_drain(20, "restart");
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_round_robin();
        test_both_vc();
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
